// File: rtl/remote_update_ctrl.sv
// Sequencer for a remote-update core: reads one configuration parameter per
// request, or issues a one-shot reconfiguration that locks the block until reset.
//
// state      | meaning
// IDLE       | waiting for start_read / start_reconfig
// RD_REQ     | one-cycle read strobe to the core
// RD_WAIT_HI | waiting for the core to raise busy
// RD_WAIT_LO | waiting for busy to fall, then capture data
// RD_DONE    | one-cycle param_valid pulse
// RECFG      | holding ru_reconfig high for RECONFIG_HOLD cycles
// RECFG_DONE | terminal; only reset leaves this state
module remote_update_ctrl #(
  parameter int unsigned DATA_W        = 29,
  parameter int unsigned TIMEOUT       = 1023,
  parameter int unsigned RECONFIG_HOLD = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_read_i,
  input  logic [2:0]        read_sel_i,
  input  logic              start_reconfig_i,
  input  logic              ru_busy_i,
  input  logic [DATA_W-1:0] ru_data_out_i,
  output logic [2:0]        ru_param_o,
  output logic              ru_read_param_o,
  output logic              ru_reconfig_o,
  output logic [DATA_W-1:0] param_data_o,
  output logic              param_valid_o,
  output logic              ctrl_busy_o,
  output logic              error_o
);

  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned HOLD_W = (RECONFIG_HOLD > 1) ? $clog2(RECONFIG_HOLD) : 1;
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RECONFIG_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT_HI,
    RD_WAIT_LO,
    RD_DONE,
    RECFG,
    RECFG_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [2:0]          ru_param_q, ru_param_d;
  logic [DATA_W-1:0]   param_data_q, param_data_d;
  logic                error_q, error_d;
  logic                ru_read_param_q;
  logic                ru_reconfig_q;
  logic                param_valid_q;
  logic                ctrl_busy_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    ru_param_d   = ru_param_q;
    param_data_d = param_data_q;
    error_d      = error_q;

    unique case (state_q)
      IDLE: begin
        // read has priority; a coincident reconfig request is dropped
        if (start_read_i) begin
          ru_param_d = read_sel_i;
          error_d    = 1'b0;
          state_d    = RD_REQ;
        end else if (start_reconfig_i && !ru_busy_i) begin
          error_d = 1'b0;
          hold_d  = HOLD_LOAD;
          state_d = RECFG;
        end
      end

      RD_REQ: begin
        cnt_d   = '0;
        state_d = RD_WAIT_HI;
      end

      RD_WAIT_HI: begin
        if (cnt_q == TIMEOUT_C) begin
          state_d = IDLE;
        end else if (ru_busy_i) begin
          cnt_d   = '0;
          state_d = RD_WAIT_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == TIMEOUT_C) error_d = 1'b1;
        end
      end

      RD_WAIT_LO: begin
        if (cnt_q == TIMEOUT_C) begin
          state_d = IDLE;
        end else if (!ru_busy_i) begin
          param_data_d = ru_data_out_i;
          state_d      = RD_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == TIMEOUT_C) error_d = 1'b1;
        end
      end

      RD_DONE: begin
        state_d = IDLE;
      end

      RECFG: begin
        if (hold_q == '0) begin
          state_d = RECFG_DONE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      RECFG_DONE: begin
        state_d = RECFG_DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // strobes are decoded from the next state so they line up with the state they mark
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      hold_q          <= '0;
      ru_param_q      <= '0;
      param_data_q    <= '0;
      error_q         <= 1'b0;
      ru_read_param_q <= 1'b0;
      ru_reconfig_q   <= 1'b0;
      param_valid_q   <= 1'b0;
      ctrl_busy_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      hold_q          <= hold_d;
      ru_param_q      <= ru_param_d;
      param_data_q    <= param_data_d;
      error_q         <= error_d;
      ru_read_param_q <= (state_d == RD_REQ);
      ru_reconfig_q   <= (state_d == RECFG);
      param_valid_q   <= (state_d == RD_DONE);
      ctrl_busy_q     <= (state_d != IDLE);
    end
  end

  assign ru_param_o      = ru_param_q;
  assign ru_read_param_o = ru_read_param_q;
  assign ru_reconfig_o   = ru_reconfig_q;
  assign param_data_o    = param_data_q;
  assign param_valid_o   = param_valid_q;
  assign ctrl_busy_o     = ctrl_busy_q;
  assign error_o         = error_q;

endmodule

// File: tb/tb_remote_update_ctrl.sv
// Directed bench for remote_update_ctrl: reads, timeout, priority, reconfig
// lockout and mid-transaction reset, with hand-computed cycle expectations.
module tb_remote_update_ctrl;

  localparam int DATA_W  = 29;
  localparam int TIMEOUT = 8;
  localparam int HOLD    = 4;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              start_read_i;
  logic [2:0]        read_sel_i;
  logic              start_reconfig_i;
  logic              ru_busy_i;
  logic [DATA_W-1:0] ru_data_out_i;
  logic [2:0]        ru_param_o;
  logic              ru_read_param_o;
  logic              ru_reconfig_o;
  logic [DATA_W-1:0] param_data_o;
  logic              param_valid_o;
  logic              ctrl_busy_o;
  logic              error_o;

  remote_update_ctrl #(
    .DATA_W       (DATA_W),
    .TIMEOUT      (TIMEOUT),
    .RECONFIG_HOLD(HOLD)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .start_read_i    (start_read_i),
    .read_sel_i      (read_sel_i),
    .start_reconfig_i(start_reconfig_i),
    .ru_busy_i       (ru_busy_i),
    .ru_data_out_i   (ru_data_out_i),
    .ru_param_o      (ru_param_o),
    .ru_read_param_o (ru_read_param_o),
    .ru_reconfig_o   (ru_reconfig_o),
    .param_data_o    (param_data_o),
    .param_valid_o   (param_valid_o),
    .ctrl_busy_o     (ctrl_busy_o),
    .error_o         (error_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_rd = 0, rd_cyc = 0;
  int n_val = 0, val_cyc = 0;
  int n_rc = 0, rc_first = 0, rc_last = 0;
  logic rc_prev = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // pulse monitor, sampled mid-cycle
  always @(negedge clk_i) begin
    if (ru_read_param_o) begin
      n_rd   <= n_rd + 1;
      rd_cyc <= cyc;
    end
    if (param_valid_o) begin
      n_val   <= n_val + 1;
      val_cyc <= cyc;
    end
    if (ru_reconfig_o) begin
      n_rc    <= n_rc + 1;
      rc_last <= cyc;
      if (!rc_prev) rc_first <= cyc;
    end
    rc_prev <= ru_reconfig_o;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  int base, rd0, val0, rc0;

  initial begin
    reset_i          = 1'b1;
    start_read_i     = 1'b0;
    read_sel_i       = 3'd0;
    start_reconfig_i = 1'b0;
    ru_busy_i        = 1'b0;
    ru_data_out_i    = '0;
    tick(3);
    check_eq("rst_ru_param", ru_param_o, 0);
    check_eq("rst_read_param", ru_read_param_o, 0);
    check_eq("rst_reconfig", ru_reconfig_o, 0);
    check_eq("rst_param_data", param_data_o, 0);
    check_eq("rst_valid", param_valid_o, 0);
    check_eq("rst_busy", ctrl_busy_o, 0);
    check_eq("rst_error", error_o, 0);
    reset_i = 1'b0;
    tick(2);

    // nominal read, with an ignored start_read in the middle
    base = cyc; rd0 = n_rd; val0 = n_val;
    start_read_i = 1'b1; read_sel_i = 3'd2;
    tick(1);
    start_read_i = 1'b0;
    check_eq("nom_busy_b1", ctrl_busy_o, 1);
    tick(2);
    ru_busy_i = 1'b1; ru_data_out_i = 29'h1555555;
    tick(2);
    start_read_i = 1'b1; read_sel_i = 3'd5;
    tick(1);
    start_read_i = 1'b0;
    tick(4);
    ru_busy_i = 1'b0; ru_data_out_i = 29'h0ABCDEF;
    tick(1);
    check_eq("nom_valid_b11", param_valid_o, 1);
    ru_data_out_i = '0;
    tick(1);
    check_eq("nom_rd_count", n_rd - rd0, 1);
    check_eq("nom_rd_cycle", rd_cyc - base, 1);
    check_eq("nom_val_count", n_val - val0, 1);
    check_eq("nom_val_cycle", val_cyc - base, 11);
    check_eq("nom_data", param_data_o, 32'h0ABCDEF);
    check_eq("nom_ru_param", ru_param_o, 2);
    check_eq("nom_busy_end", ctrl_busy_o, 0);

    // timeout with busy never raised
    base = cyc; val0 = n_val;
    start_read_i = 1'b1; read_sel_i = 3'd6;
    tick(1);
    start_read_i = 1'b0;
    tick(8);
    check_eq("to_err_b9", error_o, 0);
    check_eq("to_busy_b9", ctrl_busy_o, 1);
    tick(1);
    check_eq("to_err_b10", error_o, 1);
    check_eq("to_busy_b10", ctrl_busy_o, 1);
    tick(1);
    check_eq("to_busy_b11", ctrl_busy_o, 0);
    tick(1);
    check_eq("to_err_sticky", error_o, 1);
    check_eq("to_data_kept", param_data_o, 32'h0ABCDEF);
    check_eq("to_no_valid", n_val - val0, 0);
    check_eq("to_ru_param", ru_param_o, 6);

    // simultaneous read and reconfig: read wins
    base = cyc; val0 = n_val; rc0 = n_rc;
    start_read_i = 1'b1; start_reconfig_i = 1'b1; read_sel_i = 3'd1;
    tick(1);
    start_read_i = 1'b0; start_reconfig_i = 1'b0;
    check_eq("sim_err_cleared", error_o, 0);
    tick(2);
    ru_busy_i = 1'b1;
    tick(2);
    ru_busy_i = 1'b0; ru_data_out_i = 29'h1234567;
    tick(1);
    check_eq("sim_valid_b6", param_valid_o, 1);
    ru_data_out_i = '0;
    tick(1);
    check_eq("sim_data", param_data_o, 32'h1234567);
    check_eq("sim_val_cycle", val_cyc - base, 6);
    check_eq("sim_no_reconfig", n_rc - rc0, 0);
    check_eq("sim_busy_end", ctrl_busy_o, 0);

    // reset in RD_WAIT_LO, start_read during reset is ignored
    base = cyc; val0 = n_val;
    start_read_i = 1'b1; read_sel_i = 3'd3;
    tick(1);
    start_read_i = 1'b0;
    tick(2);
    ru_busy_i = 1'b1;
    tick(2);
    reset_i = 1'b1; start_read_i = 1'b1; read_sel_i = 3'd7;
    tick(1);
    reset_i = 1'b0; start_read_i = 1'b0; ru_busy_i = 1'b0;
    check_eq("mrst_ru_param", ru_param_o, 0);
    check_eq("mrst_data", param_data_o, 0);
    check_eq("mrst_busy", ctrl_busy_o, 0);
    check_eq("mrst_error", error_o, 0);
    check_eq("mrst_read_param", ru_read_param_o, 0);
    tick(3);
    check_eq("mrst_no_valid", n_val - val0, 0);
    check_eq("mrst_idle", ctrl_busy_o, 0);

    // read after reset completes normally
    base = cyc; rd0 = n_rd; val0 = n_val;
    start_read_i = 1'b1; read_sel_i = 3'd4;
    tick(1);
    start_read_i = 1'b0;
    tick(1);
    ru_busy_i = 1'b1;
    tick(1);
    ru_busy_i = 1'b0; ru_data_out_i = 29'h1ABCDEF;
    tick(2);
    ru_data_out_i = '0;
    check_eq("post_rd_count", n_rd - rd0, 1);
    check_eq("post_val_count", n_val - val0, 1);
    check_eq("post_val_cycle", val_cyc - base, 4);
    check_eq("post_data", param_data_o, 32'h1ABCDEF);
    check_eq("post_ru_param", ru_param_o, 4);

    // reconfig request while core busy is ignored
    rc0 = n_rc;
    ru_busy_i = 1'b1; start_reconfig_i = 1'b1;
    tick(1);
    start_reconfig_i = 1'b0; ru_busy_i = 1'b0;
    check_eq("rcbusy_idle", ctrl_busy_o, 0);
    tick(2);
    check_eq("rcbusy_no_pulse", n_rc - rc0, 0);

    // reconfig: four-cycle pulse then terminal lockout
    base = cyc; rc0 = n_rc;
    start_reconfig_i = 1'b1;
    tick(1);
    start_reconfig_i = 1'b0;
    check_eq("rc_high_b1", ru_reconfig_o, 1);
    tick(7);
    check_eq("rc_count", n_rc - rc0, HOLD);
    check_eq("rc_first", rc_first - base, 1);
    check_eq("rc_last", rc_last - base, HOLD);
    check_eq("rc_low_after", ru_reconfig_o, 0);
    check_eq("rc_busy_locked", ctrl_busy_o, 1);
    rd0 = n_rd;
    start_read_i = 1'b1; read_sel_i = 3'd5;
    tick(1);
    start_read_i = 1'b0;
    tick(3);
    check_eq("rc_no_read", n_rd - rd0, 0);
    check_eq("rc_still_busy", ctrl_busy_o, 1);
    check_eq("rc_ru_param_kept", ru_param_o, 4);

    // reset releases the lockout; reset during RECFG cuts the pulse short
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    check_eq("unlock_busy", ctrl_busy_o, 0);
    tick(1);
    base = cyc; rc0 = n_rc;
    start_reconfig_i = 1'b1;
    tick(1);
    start_reconfig_i = 1'b0;
    tick(1);
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    check_eq("rcrst_reconfig", ru_reconfig_o, 0);
    check_eq("rcrst_busy", ctrl_busy_o, 0);
    tick(3);
    check_eq("rcrst_pulse_len", n_rc - rc0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/remote_update_ctrl.md
REMOTE_UPDATE_CTRL -- requirements
Module: remote_update_ctrl

Interface
REQ-001 Parameter DATA_W, default 29: width of the parameter data word returned by the remote-update core.
REQ-002 Parameter TIMEOUT, default 1023: maximum cycles spent in any single wait state before the transaction is aborted.
REQ-003 Parameter RECONFIG_HOLD, default 4: number of cycles ru_reconfig is held high.
REQ-004 clk  input  1: single clock; all logic on its rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 start_read  input  1: single-cycle request to read one parameter.
REQ-007 read_sel  input  3: parameter select, sampled with start_read.
REQ-008 start_reconfig  input  1: single-cycle request to trigger reconfiguration.
REQ-009 ru_busy  input  1: busy flag from the remote-update core.
REQ-010 ru_data_out  input  DATA_W: parameter data from the remote-update core.
REQ-011 ru_param  output  3: parameter select to the core.
REQ-012 ru_read_param  output  1: read strobe to the core.
REQ-013 ru_reconfig  output  1: reconfiguration request to the core.
REQ-014 param_data  output  DATA_W: last successfully read parameter value.
REQ-015 param_valid  output  1: one-cycle pulse marking new param_data.
REQ-016 ctrl_busy  output  1: high whenever the FSM is not IDLE.
REQ-017 error  output  1: sticky timeout flag.

Function
REQ-018 The FSM SHALL have the states IDLE, RD_REQ, RD_WAIT_HI, RD_WAIT_LO, RD_DONE, RECFG and RECFG_DONE.
REQ-019 In IDLE, start_read=1 SHALL be accepted: read_sel latched into ru_param, error cleared, next state RD_REQ.
REQ-020 In IDLE with start_read=0, start_reconfig=1 and ru_busy=0, the request SHALL be accepted: error cleared, next state RECFG.
REQ-021 When start_read and start_reconfig are both high in IDLE, the read SHALL win and the reconfig request SHALL be dropped.
REQ-022 All start requests arriving outside IDLE SHALL be ignored, with no queuing.
REQ-023 start_reconfig in IDLE while ru_busy=1 SHALL be ignored.
REQ-024 RD_REQ SHALL assert ru_read_param for exactly one cycle (the cycle after acceptance), then go to RD_WAIT_HI.
REQ-025 RD_WAIT_HI SHALL advance to RD_WAIT_LO on the first cycle ru_busy=1.
REQ-026 RD_WAIT_LO SHALL, on the first cycle ru_busy=0, capture ru_data_out into param_data and go to RD_DONE.
REQ-027 RD_DONE SHALL assert param_valid for one cycle, then return to IDLE.
REQ-028 Read latency SHALL be: param_valid high exactly one cycle after the cycle in which RD_WAIT_LO samples ru_busy=0.
REQ-029 ru_param SHALL hold its latched value from acceptance until the next accepted read.
REQ-030 A wait counter SHALL clear on entry to RD_WAIT_HI and RD_WAIT_LO and increment each cycle spent in them.
REQ-031 When the wait counter reaches TIMEOUT, the FSM SHALL set error=1, leave param_data unchanged, skip param_valid and return to IDLE on the next cycle.
REQ-032 error SHALL stay high until reset or the next accepted request.
REQ-033 RECFG SHALL assert ru_reconfig for exactly RECONFIG_HOLD consecutive cycles, then enter RECFG_DONE.
REQ-034 RECFG_DONE SHALL be terminal: ru_reconfig=0, ctrl_busy=1, all starts ignored until reset.
REQ-035 ctrl_busy SHALL be a registered decode of state != IDLE.

Reset
REQ-036 Reset SHALL, on the clock edge where it is sampled high, force state IDLE and set ru_param=0, ru_read_param=0, ru_reconfig=0, param_data=0, param_valid=0, ctrl_busy=0, error=0 and wait counter=0.
REQ-037 Reset asserted mid-transaction, including during RECFG, SHALL abort immediately to the reset values with no pulse completed.
REQ-038 Inputs SHALL be ignored on the cycle reset is high.

Verification
REQ-039 Nominal read: start_read at cycle 10 with read_sel=3'd2; core raises busy at cycle 13 and drops it at cycle 20 with data 29'h0ABCDEF -> ru_read_param high at cycle 11 only; param_data=29'h0ABCDEF; param_valid high at cycle 21 only; ru_param=2.
REQ-040 Timeout: TIMEOUT=8, start_read with ru_busy held 0 -> error=1 after 8 wait cycles, param_valid never high, param_data unchanged, ctrl_busy drops the next cycle.
REQ-041 Simultaneous start_read and start_reconfig in IDLE -> read transaction runs; ru_reconfig stays 0 throughout.
REQ-042 Reconfig: start_reconfig with ru_busy=0 -> ru_reconfig high for exactly 4 cycles, then ctrl_busy stays 1; a following start_read produces no ru_read_param.
REQ-043 Reset asserted in RD_WAIT_LO -> next cycle all outputs at reset values; a new read afterwards completes normally.
REQ-044 start_read pulsed while ctrl_busy=1 -> ignored; exactly one ru_read_param pulse per accepted request.
